// File: rtl/fpu_mult_seq.sv
// Sequential IEEE-754 multiplier: radix-2^R iterative significand product, directed rounding.
// Define FPU_MULT_SPECIALS_EN to decode inf/NaN operands; otherwise all-ones exponents are finite.
module fpu_mult_seq #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23,
  parameter int R  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beg_FSM,
  input  logic         ack_FSM,
  input  logic [W-1:0] Data_MX,
  input  logic [W-1:0] Data_MY,
  input  logic [1:0]   round_mode,
  output logic         ready,
  output logic [W-1:0] final_result_ieee,
  output logic         overflow_flag,
  output logic         underflow_flag,
  output logic         inexact_flag,
  output logic         invalid_flag
);
  localparam int N_ITER = (SW + R) / R;
  localparam int CW     = $clog2(N_ITER + 1);
  localparam int PW     = 2 * SW + 2;
  localparam int XW     = EW + 2;
  localparam logic signed [XW-1:0] BIAS_X  = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;

  state_t                state_q;
  logic [W-1:0]          x_q, y_q, result_q;
  logic [1:0]            rm_q;
  logic                  sign_q;
  logic signed [XW-1:0]  exp_q;
  logic [PW-1:0]         p_q, mcand_q;
  logic [SW:0]           mplier_q, mant_q;
  logic [CW-1:0]         iter_q;
  logic                  guard_q, sticky_q;
  logic                  ready_q, ovf_q, unf_q, inx_q, inv_q;

  logic [EW-1:0] ex, ey;
  logic [SW-1:0] fx, fy;
  logic          sign_l, x_zero, y_zero;
  logic signed [XW-1:0] exp_sum;
  logic          short_l, short_inv_l;
  logic [W-1:0]  short_res_l;

  assign ex      = x_q[W-2:SW];
  assign ey      = y_q[W-2:SW];
  assign fx      = x_q[SW-1:0];
  assign fy      = y_q[SW-1:0];
  assign sign_l  = x_q[W-1] ^ y_q[W-1];
  assign x_zero  = (ex == '0);
  assign y_zero  = (ey == '0);
  assign exp_sum = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS_X;

  // Operands that bypass the iterative datapath and go straight to DONE.
  always_comb begin
    short_l     = 1'b0;
    short_inv_l = 1'b0;
    short_res_l = '0;
`ifdef FPU_MULT_SPECIALS_EN
    if (((&ex) && (fx != '0)) || ((&ey) && (fy != '0)) ||
        ((&ex) && y_zero) || ((&ey) && x_zero)) begin
      short_l     = 1'b1;
      short_inv_l = 1'b1;
      short_res_l = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
    end else if ((&ex) || (&ey)) begin
      short_l     = 1'b1;
      short_res_l = {sign_l, {EW{1'b1}}, {SW{1'b0}}};
    end else if (x_zero || y_zero) begin
      short_l     = 1'b1;
      short_res_l = {sign_l, {(W-1){1'b0}}};
    end
`else
    if (x_zero || y_zero) begin
      short_l     = 1'b1;
      short_res_l = {sign_l, {(W-1){1'b0}}};
    end
`endif
  end

  logic [PW-1:0] addend;
  assign addend = mcand_q * {{(PW-R){1'b0}}, mplier_q[R-1:0]};

  logic          norm_hi, guard_n, sticky_n;
  logic [SW:0]   mant_n;
  assign norm_hi  = p_q[PW-1];
  assign mant_n   = norm_hi ? p_q[PW-1:SW+1] : p_q[PW-2:SW];
  assign guard_n  = norm_hi ? p_q[SW] : p_q[SW-1];
  assign sticky_n = norm_hi ? (|p_q[SW-1:0]) : (|p_q[SW-2:0]);

  logic                 inc_d, carry_d, ovf_d, unf_d, to_inf_d;
  logic [SW+1:0]        mant_sum;
  logic [SW-1:0]        frac_d;
  logic signed [XW-1:0] exp_d;
  logic                 unused_hidden;

  always_comb begin
    inc_d = 1'b0;
    case (rm_q)
      2'b00:   inc_d = guard_q & (sticky_q | mant_q[0]);
      2'b01:   inc_d = 1'b0;
      2'b10:   inc_d = ~sign_q & (guard_q | sticky_q);
      default: inc_d = sign_q & (guard_q | sticky_q);
    endcase
  end

  assign mant_sum      = {1'b0, mant_q} + (SW+2)'(inc_d);
  assign carry_d       = mant_sum[SW+1];
  assign unused_hidden = mant_sum[SW];
  assign frac_d        = carry_d ? '0 : mant_sum[SW-1:0];
  assign exp_d         = exp_q + $signed({{(XW-1){1'b0}}, carry_d});
  assign ovf_d         = ~exp_d[XW-1] & (exp_d >= EXP_MAX);
  assign unf_d         = exp_d[XW-1] | (exp_d == '0);
  assign to_inf_d      = (rm_q == 2'b00) || (rm_q == 2'b10 && !sign_q) || (rm_q == 2'b11 && sign_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      rm_q     <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      p_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mant_q   <= '0;
      iter_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (beg_FSM) begin
          x_q     <= Data_MX;
          y_q     <= Data_MY;
          rm_q    <= round_mode;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          sign_q   <= sign_l;
          exp_q    <= exp_sum;
          p_q      <= '0;
          mcand_q  <= PW'({1'b1, fx});
          mplier_q <= {1'b1, fy};
          iter_q   <= CW'(N_ITER - 1);
          result_q <= short_res_l;
          ovf_q    <= 1'b0;
          unf_q    <= 1'b0;
          inx_q    <= 1'b0;
          inv_q    <= short_inv_l;
          if (short_l) begin
            ready_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_MULT;
          end
        end
        S_MULT: begin
          p_q      <= p_q + addend;
          mcand_q  <= mcand_q << R;
          mplier_q <= mplier_q >> R;
          iter_q   <= iter_q - 1'b1;
          if (iter_q == '0) state_q <= S_NORM;
        end
        S_NORM: begin
          exp_q    <= exp_q + $signed({{(XW-1){1'b0}}, norm_hi});
          mant_q   <= mant_n;
          guard_q  <= guard_n;
          sticky_q <= sticky_n;
          state_q  <= S_ROUND;
        end
        S_ROUND: begin
          if (ovf_d) begin
            result_q <= to_inf_d ? {sign_q, {EW{1'b1}}, {SW{1'b0}}}
                                 : {sign_q, {(EW-1){1'b1}}, 1'b0, {SW{1'b1}}};
            ovf_q    <= 1'b1;
            inx_q    <= 1'b1;
          end else if (unf_d) begin
            result_q <= {sign_q, {(W-1){1'b0}}};
            unf_q    <= 1'b1;
            inx_q    <= 1'b1;
          end else begin
            result_q <= {sign_q, exp_d[EW-1:0], frac_d};
            inx_q    <= guard_q | sticky_q;
          end
          ready_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: if (ack_FSM) begin
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready             = ready_q;
  assign final_result_ieee = result_q;
  assign overflow_flag     = ovf_q;
  assign underflow_flag    = unf_q;
  assign inexact_flag      = inx_q;
  assign invalid_flag      = inv_q;
endmodule

// File: tb/tb_fpu_mult_seq.sv
// Directed bench for fpu_mult_seq (single precision, R=4): scoreboard of expected result/flags.
module tb_fpu_mult_seq;
  localparam int N_ITER = 6;
  localparam int LAT    = N_ITER + 4;
  localparam int LAT_SC = 2;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        beg_FSM = 1'b0;
  logic        ack_FSM = 1'b0;
  logic [31:0] Data_MX = '0;
  logic [31:0] Data_MY = '0;
  logic [1:0]  round_mode = '0;
  logic        ready;
  logic [31:0] final_result_ieee;
  logic        overflow_flag, underflow_flag, inexact_flag, invalid_flag;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  fpu_mult_seq #(.W(32), .EW(8), .SW(23), .R(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .beg_FSM           (beg_FSM),
    .ack_FSM           (ack_FSM),
    .Data_MX           (Data_MX),
    .Data_MY           (Data_MY),
    .round_mode        (round_mode),
    .ready             (ready),
    .final_result_ieee (final_result_ieee),
    .overflow_flag     (overflow_flag),
    .underflow_flag    (underflow_flag),
    .inexact_flag      (inexact_flag),
    .invalid_flag      (invalid_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] flags_now();
    return {overflow_flag, underflow_flag, inexact_flag, invalid_flag};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Inputs are scrambled right after the sample edge to prove they were captured.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm);
    @(negedge clk);
    Data_MX = x; Data_MY = y; round_mode = rm; beg_FSM = 1'b1;
    @(posedge clk); #1;
    beg_FSM = 1'b0;
    Data_MX = $urandom; Data_MY = $urandom; round_mode = 2'($urandom_range(3));
  endtask

  // lat = sample edge (relative to the beg edge) at which ready is first seen high.
  task automatic wait_ready(output int lat);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (ready) lat = k + 1;
    end
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk); ack_FSM = 1'b1;
    @(posedge clk); #1; ack_FSM = 1'b0;
    check({tag, "_rdyfall"}, 32'(ready), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] rm, input logic [31:0] eres, input logic [3:0] eflg,
                        input int elat);
    int   lat;
    exp_t e;
    sb.push_back('{res: eres, flg: eflg});
    start_op(x, y, rm);
    wait_ready(lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_res"}, final_result_ieee, e.res);
      check({tag, "_flg"}, 32'(flags_now()), 32'(e.flg));
    end
    do_ack(tag);
    check({tag, "_held"}, final_result_ieee, eres);
  endtask

  initial begin
    int  lat;
    bit  seen;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_res", final_result_ieee, 32'd0);
    check("rst_flg", 32'(flags_now()), 32'd0);
    @(negedge clk); rst = 1'b0;

    // flags are {overflow, underflow, inexact, invalid}
    run_op("basic",     32'h40400000, 32'h40200000, 2'b00, 32'h40F00000, 4'b0000, LAT);
    run_op("ovf_rne",   32'h7F000000, 32'h40000000, 2'b00, 32'h7F800000, 4'b1010, LAT);
    run_op("ovf_rtz",   32'h7F000000, 32'h40000000, 2'b01, 32'h7F7FFFFF, 4'b1010, LAT);
    run_op("ovf_pinf",  32'h7F000000, 32'h40000000, 2'b10, 32'h7F800000, 4'b1010, LAT);
    run_op("ovf_minf",  32'h7F000000, 32'h40000000, 2'b11, 32'h7F7FFFFF, 4'b1010, LAT);
    run_op("novf_minf", 32'hFF000000, 32'h40000000, 2'b11, 32'hFF800000, 4'b1010, LAT);
    run_op("novf_pinf", 32'hFF000000, 32'h40000000, 2'b10, 32'hFF7FFFFF, 4'b1010, LAT);
    run_op("unf",       32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 4'b0110, LAT);
    run_op("zero",      32'h80000000, 32'h40400000, 2'b00, 32'h80000000, 4'b0000, LAT_SC);
    run_op("rnd_rne",   32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0010, LAT);
    run_op("rnd_pinf",  32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0010, LAT);
    run_op("rnd_rtz",   32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0010, LAT);
    run_op("rnd_minf",  32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800002, 4'b0010, LAT);
    run_op("nrnd_minf", 32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800003, 4'b0010, LAT);
    run_op("carry_rne", 32'h3F800001, 32'h3FFFFFFE, 2'b00, 32'h40000000, 4'b0010, LAT);
    run_op("carry_rtz", 32'h3F800001, 32'h3FFFFFFE, 2'b01, 32'h3FFFFFFF, 4'b0010, LAT);
`ifdef FPU_MULT_SPECIALS_EN
    run_op("inf_x_0",   32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b0001, LAT_SC);
    run_op("nan_x_1",   32'h7FC00001, 32'h3F800000, 2'b01, 32'h7FC00000, 4'b0001, LAT_SC);
    run_op("ninf_x_2",  32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000, 4'b0000, LAT_SC);
`else
    run_op("inf_x_0",   32'h7F800000, 32'h00000000, 2'b00, 32'h00000000, 4'b0000, LAT_SC);
    run_op("nan_x_1",   32'h7FC00001, 32'h3F800000, 2'b00, 32'h7F800000, 4'b1010, LAT);
    run_op("ninf_x_2",  32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000, 4'b1010, LAT);
`endif

    // Reset while DONE holds a nonzero result: outputs must clear without a clock edge.
    start_op(32'h40400000, 32'h40200000, 2'b00);
    wait_ready(lat);
    check("rstdone_lat", 32'(lat), 32'(LAT));
    #1 rst = 1'b1;
    #1;
    check("rstdone_ready", 32'(ready), 32'd0);
    check("rstdone_res", final_result_ieee, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset in the middle of MULT.
    start_op(32'h7F000000, 32'h40000000, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstmult_ready", 32'(ready), 32'd0);
    check("rstmult_res", final_result_ieee, 32'd0);
    check("rstmult_flg", 32'(flags_now()), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op("after_rst", 32'h40400000, 32'h40200000, 2'b00, 32'h40F00000, 4'b0000, LAT);

    // beg and ack together in DONE: ack wins, no new operation starts.
    start_op(32'h40400000, 32'h40200000, 2'b00);
    wait_ready(lat);
    check("begack_lat", 32'(lat), 32'(LAT));
    @(negedge clk);
    Data_MX = 32'h80000000; Data_MY = 32'h3F800000; ack_FSM = 1'b1; beg_FSM = 1'b1;
    @(posedge clk); #1;
    ack_FSM = 1'b0; beg_FSM = 1'b0;
    check("begack_rdyfall", 32'(ready), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    check("begack_nostart", 32'(seen), 32'd0);
    run_op("after_begack", 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0010, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
